commit_store_queue: RTL and testbench

//  Responder side of the commit-stage store handshake (commit_lsu / commit_lsu_ready / no_st_pending).
//  - Holds speculative stores from the LSU until the commit stage retires them.
//  - Moves each retired store to a committed queue, then drains that queue to the D$ in order.
//  - Reports store-pending status and page-offset hazards to the load path.

---
 rtl/commit_store_queue_pkg.sv | 16 +
 rtl/commit_store_queue_store_ring.sv | 75 +++++++
 rtl/commit_store_queue.sv | 139 +++++++++++++
 tb/tb_commit_store_queue.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_store_queue_pkg.sv
// Shared types and default sizes for the commit-stage store queue.
package commit_store_queue_pkg;

    localparam int XLEN = 64;
    localparam int PLEN = 56;
    localparam int SPEC_DEPTH_DEF = 4;
    localparam int COMMIT_DEPTH_DEF = 4;

    typedef struct packed {
        logic [PLEN-1:0]   paddr;
        logic [XLEN-1:0]   data;
        logic [XLEN/8-1:0] be;
        logic [1:0]        size;
    } store_entry_t;

endpackage

// File: rtl/commit_store_queue_store_ring.sv
// Circular store buffer with push, pop, clear and per-slot valid bits.
module store_ring #(
    parameter int DEPTH = 4,
    parameter type entry_t = logic [7:0],
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          push_i,
    input  entry_t        data_i,
    input  logic          pop_i,
    output entry_t        head_o,
    output logic [CW-1:0] count_o,
    output logic [DEPTH-1:0] valid_o,
    output entry_t        mem_o [DEPTH]
);

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Clear wins over push and pop; a pop on clear is implied by the clear.
    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_q] = data_i;
                wr_d = wr_q + PW'(1);
            end
            if (pop_i) begin
                rd_d = rd_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        valid_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_o[i] = CW'(PW'(i) - rd_q) < cnt_q;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign mem_o   = mem_q;

endmodule

// File: rtl/commit_store_queue.sv
// Speculative + committed store queues feeding the D$ in program order,
// with store-pending status and page-offset hazard detection for loads.
module commit_store_queue
    import commit_store_queue_pkg::*;
#(
    parameter int SPEC_DEPTH   = SPEC_DEPTH_DEF,
    parameter int COMMIT_DEPTH = COMMIT_DEPTH_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [PLEN-1:0]   paddr_i,
    input  logic [XLEN-1:0]   data_i,
    input  logic [XLEN/8-1:0] be_i,
    input  logic [1:0]        data_size_i,
    output logic              ready_o,
    input  logic              commit_i,
    output logic              commit_ready_o,
    output logic              no_st_pending_o,
    input  logic [11:0]       page_offset_i,
    output logic              page_offset_match_o,
    output logic              req_o,
    output logic [PLEN-1:0]   addr_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [XLEN/8-1:0] be_o,
    output logic [1:0]        size_o,
    input  logic              gnt_i
);

    localparam int SCW = $clog2(SPEC_DEPTH + 1);
    localparam int CCW = $clog2(COMMIT_DEPTH + 1);

    store_entry_t           in_entry;
    store_entry_t           spec_head;
    store_entry_t           com_head;
    store_entry_t           spec_mem [SPEC_DEPTH];
    store_entry_t           com_mem  [COMMIT_DEPTH];
    logic [SCW-1:0]         spec_cnt;
    logic [CCW-1:0]         com_cnt;
    logic [SPEC_DEPTH-1:0]  spec_vld;
    logic [COMMIT_DEPTH-1:0] com_vld;
    logic                   spec_push;
    logic                   commit_go;
    logic                   drain_pop;
    logic                   unused_ok;

    assign in_entry = '{paddr: paddr_i, data: data_i,
                        be: be_i, size: data_size_i};

    assign ready_o        = spec_cnt < SCW'(SPEC_DEPTH);
    assign commit_ready_o = com_cnt < CCW'(COMMIT_DEPTH);
    assign no_st_pending_o = com_cnt == '0;
    assign req_o          = com_cnt != '0;

    assign spec_push = valid_i & ready_o & ~flush_i;
    assign commit_go = commit_i & commit_ready_o & (spec_cnt != '0);
    assign drain_pop = req_o & gnt_i;

    store_ring #(
        .DEPTH   (SPEC_DEPTH),
        .entry_t (store_entry_t)
    ) u_spec (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (flush_i),
        .push_i  (spec_push),
        .data_i  (in_entry),
        .pop_i   (commit_go),
        .head_o  (spec_head),
        .count_o (spec_cnt),
        .valid_o (spec_vld),
        .mem_o   (spec_mem)
    );

    store_ring #(
        .DEPTH   (COMMIT_DEPTH),
        .entry_t (store_entry_t)
    ) u_commit (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (1'b0),
        .push_i  (commit_go),
        .data_i  (spec_head),
        .pop_i   (drain_pop),
        .head_o  (com_head),
        .count_o (com_cnt),
        .valid_o (com_vld),
        .mem_o   (com_mem)
    );

    // Outputs held at zero when idle so the D$ port is quiet after reset.
    assign addr_o  = req_o ? com_head.paddr : '0;
    assign wdata_o = req_o ? com_head.data  : '0;
    assign be_o    = req_o ? com_head.be    : '0;
    assign size_o  = req_o ? com_head.size  : '0;

    always_comb begin
        page_offset_match_o = valid_i &
            (paddr_i[11:3] == page_offset_i[11:3]);
        for (int i = 0; i < SPEC_DEPTH; i++) begin
            if (spec_vld[i] &&
                spec_mem[i].paddr[11:3] == page_offset_i[11:3])
                page_offset_match_o = 1'b1;
        end
        for (int i = 0; i < COMMIT_DEPTH; i++) begin
            if (com_vld[i] &&
                com_mem[i].paddr[11:3] == page_offset_i[11:3])
                page_offset_match_o = 1'b1;
        end
    end

    always_comb begin
        unused_ok = ^page_offset_i[2:0];
        for (int i = 0; i < SPEC_DEPTH; i++) begin
            unused_ok = unused_ok ^ (^spec_mem[i]);
        end
        for (int i = 0; i < COMMIT_DEPTH; i++) begin
            unused_ok = unused_ok ^ (^com_mem[i]);
        end
    end

    a_push_full : assert property (@(posedge clk_i) disable iff (rst_i)
        !(valid_i && !ready_o))
        else $error("store pushed while speculative queue full");
    a_commit_empty : assert property (@(posedge clk_i) disable iff (rst_i)
        !(commit_i && spec_cnt == '0))
        else $error("commit with no speculative store");
    a_commit_full : assert property (@(posedge clk_i) disable iff (rst_i)
        !(commit_i && !commit_ready_o))
        else $error("commit while committed queue full");
    a_spec_bound : assert property (@(posedge clk_i) disable iff (rst_i)
        spec_cnt <= SCW'(SPEC_DEPTH))
        else $error("speculative count overflow");
    a_com_bound : assert property (@(posedge clk_i) disable iff (rst_i)
        com_cnt <= CCW'(COMMIT_DEPTH))
        else $error("committed count overflow");

endmodule

// File: tb/tb_commit_store_queue.sv
// Directed vector bench for commit_store_queue.
module tb_commit_store_queue;
    import commit_store_queue_pkg::*;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic              valid_i;
    logic [PLEN-1:0]   paddr_i;
    logic [XLEN-1:0]   data_i;
    logic [XLEN/8-1:0] be_i;
    logic [1:0]        data_size_i;
    logic              ready_o;
    logic              commit_i;
    logic              commit_ready_o;
    logic              no_st_pending_o;
    logic [11:0]       page_offset_i;
    logic              page_offset_match_o;
    logic              req_o;
    logic [PLEN-1:0]   addr_o;
    logic [XLEN-1:0]   wdata_o;
    logic [XLEN/8-1:0] be_o;
    logic [1:0]        size_o;
    logic              gnt_i;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    commit_store_queue dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .flush_i             (flush_i),
        .valid_i             (valid_i),
        .paddr_i             (paddr_i),
        .data_i              (data_i),
        .be_i                (be_i),
        .data_size_i         (data_size_i),
        .ready_o             (ready_o),
        .commit_i            (commit_i),
        .commit_ready_o      (commit_ready_o),
        .no_st_pending_o     (no_st_pending_o),
        .page_offset_i       (page_offset_i),
        .page_offset_match_o (page_offset_match_o),
        .req_o               (req_o),
        .addr_o              (addr_o),
        .wdata_o             (wdata_o),
        .be_o                (be_o),
        .size_o              (size_o),
        .gnt_i               (gnt_i)
    );

    typedef struct {
        logic            v;
        logic [PLEN-1:0] pa;
        logic            cm;
        logic            fl;
        logic            gn;
        logic [11:0]     po;
        logic            rdy;
        logic            crdy;
        logic            nsp;
        logic            req;
        logic [PLEN-1:0] addr;
        logic            m;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(
        input logic v, input logic [PLEN-1:0] pa,
        input logic cm, input logic fl, input logic gn,
        input logic [11:0] po,
        input logic rdy, input logic crdy, input logic nsp,
        input logic req, input logic [PLEN-1:0] addr, input logic m);
        vec_t r;
        r.v = v; r.pa = pa; r.cm = cm; r.fl = fl; r.gn = gn; r.po = po;
        r.rdy = rdy; r.crdy = crdy; r.nsp = nsp;
        r.req = req; r.addr = addr; r.m = m;
        return r;
    endfunction

    task automatic chk(input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [PLEN-1:0] pa,
                         input logic cm, input logic fl, input logic gn);
        @(negedge clk);
        valid_i  = v;
        paddr_i  = pa;
        data_i   = {8'h00, pa};
        commit_i = cm;
        flush_i  = fl;
        gnt_i    = gn;
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        flush_i = 1'b0; valid_i = 1'b0; commit_i = 1'b0; gnt_i = 1'b0;
        paddr_i = '0; data_i = '0; be_i = 8'hFF; data_size_i = 2'd3;
        page_offset_i = 12'hFF8;

        tbl[0]  = mk(1, 'h1000, 0, 0, 0, 12'hFF8, 1, 1, 1, 0, 'h0, 0);
        tbl[1]  = mk(0, 'h0, 1, 0, 0, 12'hFF8, 1, 1, 1, 0, 'h0, 0);
        tbl[2]  = mk(0, 'h0, 0, 0, 1, 12'hFF8, 1, 1, 0, 1, 'h1000, 0);
        tbl[3]  = mk(0, 'h0, 0, 0, 0, 12'hFF8, 1, 1, 1, 0, 'h0, 0);
        tbl[4]  = mk(1, 'h20A48, 0, 0, 0, 12'hA4C, 1, 1, 1, 0, 'h0, 1);
        tbl[5]  = mk(0, 'h0, 0, 0, 0, 12'hA4C, 1, 1, 1, 0, 'h0, 1);
        tbl[6]  = mk(0, 'h0, 0, 0, 0, 12'hA50, 1, 1, 1, 0, 'h0, 0);
        tbl[7]  = mk(0, 'h0, 1, 0, 0, 12'hA50, 1, 1, 1, 0, 'h0, 0);
        tbl[8]  = mk(0, 'h0, 0, 0, 0, 12'hA4C, 1, 1, 0, 1, 'h20A48, 1);
        tbl[9]  = mk(0, 'h0, 0, 0, 1, 12'hA50, 1, 1, 0, 1, 'h20A48, 0);
        tbl[10] = mk(0, 'h0, 0, 0, 1, 12'hFF8, 1, 1, 1, 0, 'h0, 0);
        tbl[11] = mk(1, 'h3000, 0, 0, 0, 12'hFF8, 1, 1, 1, 0, 'h0, 0);
        tbl[12] = mk(1, 'h3008, 0, 0, 0, 12'hFF8, 1, 1, 1, 0, 'h0, 0);
        tbl[13] = mk(1, 'h3010, 0, 0, 0, 12'hFF8, 1, 1, 1, 0, 'h0, 0);
        tbl[14] = mk(1, 'h3018, 0, 0, 0, 12'hFF8, 1, 1, 1, 0, 'h0, 0);
        tbl[15] = mk(0, 'h0, 1, 0, 0, 12'hFF8, 0, 1, 1, 0, 'h0, 0);
        tbl[16] = mk(0, 'h0, 1, 0, 0, 12'hFF8, 1, 1, 0, 1, 'h3000, 0);
        tbl[17] = mk(0, 'h0, 0, 1, 0, 12'hFF8, 1, 1, 0, 1, 'h3000, 0);
        tbl[18] = mk(0, 'h0, 0, 0, 1, 12'hFF8, 1, 1, 0, 1, 'h3000, 0);
        tbl[19] = mk(0, 'h0, 0, 0, 1, 12'hFF8, 1, 1, 0, 1, 'h3008, 0);
        tbl[20] = mk(0, 'h0, 0, 0, 1, 12'hFF8, 1, 1, 1, 0, 'h0, 0);

        repeat (2) @(negedge clk);
        #1;
        chk("rst.req", req_o, 0);
        chk("rst.ready", ready_o, 1);
        chk("rst.commit_ready", commit_ready_o, 1);
        chk("rst.no_st_pending", no_st_pending_o, 1);
        chk("rst.match", page_offset_match_o, 0);
        chk("rst.addr", addr_o, 0);
        chk("rst.wdata", wdata_o, 0);
        @(negedge clk);
        rst_i = 1'b0;

        for (int i = 0; i < 21; i++) begin
            page_offset_i = tbl[i].po;
            drive(tbl[i].v, tbl[i].pa, tbl[i].cm, tbl[i].fl, tbl[i].gn);
            chk($sformatf("vec%0d.ready", i), ready_o, tbl[i].rdy);
            chk($sformatf("vec%0d.commit_ready", i), commit_ready_o, tbl[i].crdy);
            chk($sformatf("vec%0d.no_st_pending", i), no_st_pending_o, tbl[i].nsp);
            chk($sformatf("vec%0d.req", i), req_o, tbl[i].req);
            chk($sformatf("vec%0d.addr", i), addr_o, tbl[i].addr);
            chk($sformatf("vec%0d.match", i), page_offset_match_o, tbl[i].m);
        end
        page_offset_i = 12'hFF8;

        // Fill the committed queue with the D$ stalled.
        drive(1, 'h4000, 0, 0, 0);
        drive(1, 'h4008, 0, 0, 0);
        drive(1, 'h4010, 0, 0, 0);
        drive(1, 'h4018, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 'h0, 1, 0, 0);
            chk($sformatf("full.crdy_pre%0d", i), commit_ready_o, 1);
        end
        drive(0, 'h0, 0, 0, 0);
        chk("full.commit_ready", commit_ready_o, 0);
        chk("full.ready", ready_o, 1);
        chk("full.req", req_o, 1);
        chk("full.addr", addr_o, 'h4000);
        chk("full.wdata", wdata_o, 'h4000);
        chk("full.be", be_o, 8'hFF);
        chk("full.size", size_o, 2'd3);
        drive(0, 'h0, 0, 0, 1);
        chk("full.crdy_gnt", commit_ready_o, 0);
        drive(0, 'h0, 0, 0, 0);
        chk("full.crdy_after", commit_ready_o, 1);
        chk("full.addr1", addr_o, 'h4008);
        drive(0, 'h0, 0, 0, 1);
        chk("full.d1", addr_o, 'h4008);
        drive(0, 'h0, 0, 0, 1);
        chk("full.d2", addr_o, 'h4010);
        drive(0, 'h0, 0, 0, 1);
        chk("full.d3", addr_o, 'h4018);
        drive(0, 'h0, 0, 0, 0);
        chk("full.empty_req", req_o, 0);
        chk("full.empty_nsp", no_st_pending_o, 1);

        // Commit and flush in the same cycle.
        page_offset_i = 12'h008;
        drive(1, 'h5000, 0, 0, 0);
        drive(1, 'h5008, 0, 0, 0);
        drive(0, 'h0, 1, 1, 0);
        chk("cf.match_pre", page_offset_match_o, 1);
        drive(0, 'h0, 0, 0, 0);
        chk("cf.req", req_o, 1);
        chk("cf.addr", addr_o, 'h5000);
        chk("cf.ready", ready_o, 1);
        chk("cf.match_post", page_offset_match_o, 0);
        drive(0, 'h0, 0, 0, 1);
        chk("cf.addr_gnt", addr_o, 'h5000);
        drive(0, 'h0, 0, 0, 0);
        chk("cf.req_done", req_o, 0);
        chk("cf.nsp", no_st_pending_o, 1);
        page_offset_i = 12'hFF8;

        // Push with commit, then commit with grant.
        drive(1, 'h6000, 0, 0, 0);
        drive(1, 'h6008, 1, 0, 0);
        chk("pc.req0", req_o, 0);
        drive(0, 'h0, 1, 0, 1);
        chk("pc.addr0", addr_o, 'h6000);
        drive(0, 'h0, 0, 0, 0);
        chk("pc.req1", req_o, 1);
        chk("pc.addr1", addr_o, 'h6008);
        drive(0, 'h0, 0, 0, 1);
        chk("pc.addr1g", addr_o, 'h6008);
        drive(0, 'h0, 0, 0, 0);
        chk("pc.req_done", req_o, 0);
        chk("pc.nsp", no_st_pending_o, 1);

        // Reset with a committed store outstanding.
        drive(1, 'h7000, 0, 0, 0);
        drive(0, 'h0, 1, 0, 0);
        drive(0, 'h0, 0, 0, 0);
        chk("mr.req_pre", req_o, 1);
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        chk("mr.req", req_o, 0);
        chk("mr.nsp", no_st_pending_o, 1);
        chk("mr.addr", addr_o, 0);
        chk("mr.ready", ready_o, 1);
        chk("mr.crdy", commit_ready_o, 1);
        @(negedge clk);
        rst_i = 1'b0;
        drive(0, 'h0, 0, 0, 0);
        chk("mr.req_after", req_o, 0);
        chk("mr.nsp_after", no_st_pending_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
